// File: rtl/lod_norm_pipe_pkg.sv
// Shared defaults and helpers for the leading-one normaliser.
package lod_norm_pipe_pkg;

  localparam int X_LEN_DEFAULT   = 74;
  localparam int GROUP_W_DEFAULT = 8;

  function automatic int ngroup(input int x_len, input int group_w);
    return (x_len + group_w - 1) / group_w;
  endfunction

endpackage

// File: rtl/lod_group_enc.sv
// GROUP_W-bit priority encoder: index of the leading one, 0 = group MSB.
module lod_group_enc
  import lod_norm_pipe_pkg::*;
#(
  parameter int GROUP_W = GROUP_W_DEFAULT,
  parameter int IDX_W   = $clog2(GROUP_W)
) (
  input  logic [GROUP_W-1:0] data_i,
  output logic               zero_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    zero_o = ~|data_i;
    idx_o  = '0;
    // Scan upward so the highest set bit has the final word.
    for (int i = 0; i < GROUP_W; i++) begin
      if (data_i[i]) idx_o = IDX_W'(GROUP_W - 1 - i);
    end
  end

endmodule

// File: rtl/lod_norm_pipe.sv
// Two-stage leading-one detect and left-normalise with valid/ready flow control.
// Define LOD_LIMIT_EN to clamp the shift to limit_i (subnormal support).
module lod_norm_pipe
  import lod_norm_pipe_pkg::*;
#(
  parameter int X_LEN   = X_LEN_DEFAULT,
  parameter int GROUP_W = GROUP_W_DEFAULT,
  parameter int SHIFT_W = $clog2(X_LEN)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [X_LEN-1:0]   data_i,
  input  logic [SHIFT_W-1:0] limit_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [X_LEN-1:0]   data_o,
  output logic [SHIFT_W-1:0] shift_num_o,
  output logic               allzero_o,
  output logic               limited_o
);

  localparam int NGROUP = ngroup(X_LEN, GROUP_W);
  localparam int PW     = NGROUP * GROUP_W;
  localparam int PAD    = PW - X_LEN;
  localparam int IDX_W  = $clog2(GROUP_W);

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] lz,
                                                     input logic [SHIFT_W-1:0] lim);
    return (lz > lim) ? lim : lz;
  endfunction

  // Padding sits below the LSB, so group offsets count from the data MSB unchanged.
  logic [PW-1:0]     padded;
  logic [NGROUP-1:0] zero_c;
  logic [IDX_W-1:0]  idx_c [NGROUP];

  assign padded = PW'(data_i) << PAD;

  for (genvar g = 0; g < NGROUP; g++) begin : g_enc
    lod_group_enc #(.GROUP_W(GROUP_W), .IDX_W(IDX_W)) u_enc (
      .data_i (padded[PW-1-g*GROUP_W -: GROUP_W]),
      .zero_o (zero_c[g]),
      .idx_o  (idx_c[g])
    );
  end

  logic vld_p1, vld_p2, s2_adv;

  assign s2_adv  = !vld_p2 || ready_i;
  assign ready_o = !vld_p1 || s2_adv;
  assign valid_o = vld_p2;

  // ---- S1: detect ----
  logic [X_LEN-1:0]  data_p1;
  logic [NGROUP-1:0] zero_p1;
  logic [IDX_W-1:0]  idx_p1 [NGROUP];
`ifdef LOD_LIMIT_EN
  logic [SHIFT_W-1:0] limit_p1;
`else
  logic unused_limit;
  assign unused_limit = ^limit_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) vld_p1 <= 1'b0;
    else if (ready_o) vld_p1 <= valid_i;
  end

  always_ff @(posedge clk_i) begin
    if (ready_o && valid_i) begin
      data_p1  <= data_i;
      zero_p1  <= zero_c;
      idx_p1   <= idx_c;
`ifdef LOD_LIMIT_EN
      limit_p1 <= limit_i;
`endif
    end
  end

  // ---- S2: encode and shift ----
  logic [SHIFT_W-1:0] lead_zeros, shift_c;
  logic               allzero_c, limited_c;

  always_comb begin
    lead_zeros = '0;
    allzero_c  = &zero_p1;
    for (int g = NGROUP - 1; g >= 0; g--) begin
      if (!zero_p1[g]) lead_zeros = SHIFT_W'(g * GROUP_W + int'(idx_p1[g]));
    end
`ifdef LOD_LIMIT_EN
    shift_c   = allzero_c ? '0 : clamp_shift(lead_zeros, limit_p1);
    limited_c = !allzero_c && (lead_zeros > limit_p1);
`else
    shift_c   = lead_zeros;
    limited_c = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p2      <= 1'b0;
      data_o      <= '0;
      shift_num_o <= '0;
      allzero_o   <= 1'b0;
      limited_o   <= 1'b0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_o      <= data_p1 << shift_c;
        shift_num_o <= shift_c;
        allzero_o   <= allzero_c;
        limited_o   <= limited_c;
      end
    end
  end

endmodule

// File: tb/tb_lod_norm_pipe.sv
// Bench for lod_norm_pipe: reference model with scoreboard plus directed literal vectors.
module tb_lod_norm_pipe;

  localparam int XL  = 74;
  localparam int SW  = 7;
  localparam int XB  = 53;
  localparam int SWB = 6;
`ifdef LOD_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          valid_i, ready_o, valid_o, ready_i, allzero_o, limited_o;
  logic [XL-1:0] data_i, data_o;
  logic [SW-1:0] limit_i, shift_num_o;

  logic           vb_i, rb_o, vb_o, rb_i, zb_o, lb_o;
  logic [XB-1:0]  db_i, db_o;
  logic [SWB-1:0] limb_i, sb_o;

  lod_norm_pipe #(.X_LEN(XL), .GROUP_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .limit_i(limit_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .shift_num_o(shift_num_o), .allzero_o(allzero_o),
    .limited_o(limited_o)
  );

  lod_norm_pipe #(.X_LEN(XB), .GROUP_W(8)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .valid_i(vb_i), .ready_o(rb_o),
    .data_i(db_i), .limit_i(limb_i), .valid_o(vb_o), .ready_i(rb_i),
    .data_o(db_o), .shift_num_o(sb_o), .allzero_o(zb_o), .limited_o(lb_o)
  );

  typedef struct packed {
    logic [XL-1:0] d;
    logic [SW-1:0] s;
    logic          z;
    logic          l;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Leading-zero count by a plain MSB-first scan, then shift/clamp by the rules.
  function automatic exp_t model(input logic [XL-1:0] d, input logic [SW-1:0] lim);
    exp_t e;
    int   lz;
    e  = '0;
    lz = XL;
    for (int i = XL - 1; i >= 0; i--) begin
      if (d[i]) begin
        lz = XL - 1 - i;
        break;
      end
    end
    if (lz == XL) begin
      e.z = 1'b1;
      return e;
    end
    e.s = SW'(lz);
    if (LIMIT_ON && lz > int'(lim)) begin
      e.s = lim;
      e.l = 1'b1;
    end
    e.d = d << e.s;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic logic [XL-1:0] rnd_word();
    logic [XL-1:0] w;
    int            k;
    w[31:0]  = $urandom;
    w[63:32] = $urandom;
    w[73:64] = 10'($urandom);
    k = $urandom_range(0, XL);
    return (k == XL) ? '0 : (w >> k);
  endfunction

  // One word through the main instance with literal expectations and a latency check.
  task automatic run1(input string nm, input logic [XL-1:0] d, input logic [SW-1:0] lim,
                      input logic [XL-1:0] ed, input logic [SW-1:0] es,
                      input logic ez, input logic el);
    chk({nm, " model"}, model(d, lim), {ed, es, ez, el});
    valid_i = 1'b1;
    data_i  = d;
    limit_i = lim;
    @(posedge clk); #1;
    valid_i = 1'b0;
    data_i  = rnd_word();
    chk({nm, " lat1"}, valid_o, 1'b0);
    @(posedge clk); #1;
    chk({nm, " lat2"}, valid_o, 1'b1);
    chk(nm, {data_o, shift_num_o, allzero_o, limited_o}, {ed, es, ez, el});
    @(posedge clk); #1;
  endtask

  task automatic run_b(input string nm, input logic [XB-1:0] d,
                       input logic [XB-1:0] ed, input logic [SWB-1:0] es);
    vb_i = 1'b1;
    db_i = d;
    @(posedge clk); #1;
    vb_i = 1'b0;
    @(posedge clk); #1;
    chk({nm, " valid"}, vb_o, 1'b1);
    chk(nm, {db_o, sb_o, zb_o, lb_o}, {ed, es, 1'b0, 1'b0});
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hold_prev;
    exp_t prev, e;
    int   sent, cyc, waitc;
    bit   acc;

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; data_i = '0; limit_i = SW'(73);
    vb_i = 1'b0; rb_i = 1'b1; db_i = '0; limb_i = SWB'(52);
    hold_prev = 1'b0;
    prev = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst_i) begin
          q.delete();
          hold_prev = 1'b0;
          continue;
        end
        chk("ready_o", ready_o, !(q.size() == 2 && !ready_i));
        if (hold_prev)
          chk("stall hold", {valid_o, data_o, shift_num_o, allzero_o, limited_o}, {1'b1, prev});
        if (valid_o && q.size() == 0) chk("spurious valid_o", valid_o, 1'b0);
        if (valid_o && ready_i && q.size() > 0) begin
          e = q.pop_front();
          chk("stream out", {data_o, shift_num_o, allzero_o, limited_o}, e);
        end
        hold_prev = valid_o && !ready_i;
        prev = {data_o, shift_num_o, allzero_o, limited_o};
        if (valid_i && ready_o) q.push_back(model(data_i, limit_i));
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("reset valid_o", valid_o, 1'b0);
    chk("reset ready_o", ready_o, 1'b1);
    chk("reset outs", {data_o, shift_num_o, allzero_o, limited_o}, '0);
    chk("reset b", {vb_o, rb_o}, 2'b01);

    run1("msb", XL'(1) << 73, SW'(73), XL'(1) << 73, SW'(0), 1'b0, 1'b0);
    run1("lsb", XL'(1), SW'(73), XL'(1) << 73, SW'(73), 1'b0, 1'b0);
    run1("zero", '0, SW'(73), '0, SW'(0), 1'b1, 1'b0);
    run1("three", XL'(3), SW'(73), XL'(3) << 72, SW'(72), 1'b0, 1'b0);
    run1("mid", (XL'(1) << 40) | XL'(5), SW'(73),
         (XL'(1) << 73) | (XL'(5) << 33), SW'(33), 1'b0, 1'b0);
`ifdef LOD_LIMIT_EN
    run1("clamp10", XL'(1), SW'(10), XL'(1) << 10, SW'(10), 1'b0, 1'b1);
    run1("clamp73", XL'(1), SW'(73), XL'(1) << 73, SW'(73), 1'b0, 1'b0);
    run1("zero lim0", '0, SW'(0), '0, SW'(0), 1'b1, 1'b0);
    run1("equal lim", XL'(1) << 60, SW'(13), XL'(1) << 73, SW'(13), 1'b0, 1'b0);
`else
    run1("lim ignored", XL'(1), SW'(10), XL'(1) << 73, SW'(73), 1'b0, 1'b0);
`endif

    run_b("b top", XB'(1) << 52, XB'(1) << 52, SWB'(0));
    run_b("b part lsb", XB'(1) << 48, XB'(1) << 52, SWB'(4));
    run_b("b grp1 msb", XB'(1) << 47, XB'(1) << 52, SWB'(5));
    run_b("b grp1 lsb", XB'(1) << 44, XB'(1) << 52, SWB'(8));
    run_b("b one", XB'(1), XB'(1) << 52, SWB'(52));

    // Random stream with random back-pressure
    sent = 0;
    cyc = 0;
    valid_i = 1'b0;
    while (sent < 100 && cyc < 5000) begin
      if (!valid_i && $urandom_range(0, 9) < 8) begin
        valid_i = 1'b1;
        data_i  = rnd_word();
        limit_i = SW'($urandom_range(0, 73));
      end
      ready_i = ($urandom_range(0, 99) < 65);
      #1;
      acc = valid_i && ready_o;
      if (acc) sent++;
      @(posedge clk); #1;
      if (acc) valid_i = 1'b0;
      cyc++;
    end
    valid_i = 1'b0;
    chk("stream sent", sent, 100);
    ready_i = 1'b1;
    waitc = 0;
    while (q.size() != 0 && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("stream drained", q.size(), 0);

    // Fill both stages, then reset mid-flight
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = XL'(1) << 20;
    limit_i = SW'(73);
    @(posedge clk); #1;
    data_i = XL'(7);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("full ready_o", ready_o, 1'b0);
    chk("full valid_o", valid_o, 1'b1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("rst flight valid_o", valid_o, 1'b0);
    chk("rst flight ready_o", ready_o, 1'b1);
    chk("rst flight outs", {data_o, shift_num_o, allzero_o, limited_o}, '0);
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post-reset idle", valid_o, 1'b0);
    end

    run1("after reset", XL'(1) << 9, SW'(73), XL'(1) << 73, SW'(64), 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
